// File: rtl/rf_seq_pkg.sv
// Shared types and sizes for the register-file block sequencer.
package rf_seq_pkg;

  localparam int RF_DW = 8;
  localparam int RF_PW = 4;

  typedef enum logic [1:0] {
    CLEAR = 2'b00,
    LOAD  = 2'b01,
    DUMP  = 2'b10,
    RSVD  = 2'b11
  } rf_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_DUMP,
    ST_DONE
  } rf_seq_state_t;

endpackage

// File: rtl/rf_seq_ostage.sv
// One-entry valid/ready output register for the DUMP byte stream.
module rf_seq_ostage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_can_load,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  // A new byte may enter when the slot is empty or being drained this cycle.
  assign o_can_load = !r_valid || i_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/rf_seq.sv
// Register-file block sequencer (CLEAR / LOAD / DUMP over a wrapping range).
// Optional checksum accumulator enabled by defining RF_SEQ_CSUM_EN.
module rf_seq
  import rf_seq_pkg::*;
#(
  parameter int PW = RF_PW,
  parameter int DW = RF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [PW-1:0] cmd_base,
  input  logic [PW:0]   cmd_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          rf_wr_en,
  output logic [PW-1:0] rf_addr,
  output logic [DW-1:0] rf_wdat,
  input  logic [DW-1:0] rf_rdat,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] csum
);

  localparam logic [PW:0] MAX_LEN = {1'b1, {PW{1'b0}}};
  localparam logic [PW:0] ONE     = {{PW{1'b0}}, 1'b1};

  rf_seq_state_t r_state, w_next_state;
  logic [PW-1:0] r_ptr;
  logic [PW:0]   r_cnt;

  logic          w_accept;
  logic [PW:0]   w_len;
  logic          w_in_hs;
  logic          w_out_hs;
  logic          w_can_load;
  logic          w_load;
  logic          w_step;

  assign w_accept = cmd_valid && cmd_ready;
  assign w_len    = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = out_valid && out_ready;
  // In DUMP the count tracks fetches; the last byte may still sit in the output stage.
  assign w_load   = (r_state == ST_DUMP) && (r_cnt != '0) && w_can_load;
  assign w_step   = (r_state == ST_CLEAR) || ((r_state == ST_LOAD) && in_valid) || w_load;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_len == '0 || rf_op_t'(cmd_op) == RSVD) w_next_state = ST_DONE;
          else if (rf_op_t'(cmd_op) == CLEAR)          w_next_state = ST_CLEAR;
          else if (rf_op_t'(cmd_op) == LOAD)           w_next_state = ST_LOAD;
          else                                         w_next_state = ST_DUMP;
        end
      end
      ST_CLEAR: if (r_cnt == ONE) w_next_state = ST_DONE;
      ST_LOAD:  if (in_valid && r_cnt == ONE) w_next_state = ST_DONE;
      ST_DUMP:  if (r_cnt == '0 && w_out_hs) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    rf_wr_en = 1'b0;
    rf_addr  = '0;
    rf_wdat  = '0;
    case (r_state)
      ST_CLEAR: begin
        rf_wr_en = rst_n;
        rf_addr  = r_ptr;
      end
      ST_LOAD: begin
        rf_wr_en = in_valid && rst_n;
        rf_addr  = r_ptr;
        rf_wdat  = in_data;
      end
      ST_DUMP:  rf_addr = r_ptr;
      default:  ;
    endcase
  end

  assign in_ready  = (r_state == ST_LOAD) && rst_n;
  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);

  // Pointer wraps naturally at 2**PW.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_ptr <= cmd_base;
      r_cnt <= w_len;
    end else if (w_step) begin
      r_ptr <= r_ptr + 1'b1;
      r_cnt <= r_cnt - ONE;
    end
  end

  rf_seq_ostage #(.DW(DW)) u_ostage (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_data     (rf_rdat),
    .i_ready    (out_ready),
    .o_can_load (w_can_load),
    .o_valid    (out_valid),
    .o_data     (out_data)
  );

`ifdef RF_SEQ_CSUM_EN
  logic [DW-1:0] r_csum;

  always_ff @(posedge clk) begin
    if (!rst_n)                              r_csum <= '0;
    else if (w_accept)                       r_csum <= '0;
    else if (r_state == ST_LOAD && w_in_hs)  r_csum <= r_csum + in_data;
    else if (r_state == ST_DUMP && w_out_hs) r_csum <= r_csum + out_data;
  end

  assign csum = r_csum;
`else
  assign csum = '0;
`endif

endmodule
